// File: rtl/joypad_port.sv
// joypad_port: bus responder for the two controller ports at BASE_ADDR and BASE_ADDR+1.
// It latches the OUT bits on a port-0 write.
// It shifts serial button data back on reads, one bit per committed read.
// Optional macro JOYPAD_SYNC_EN: adds 2-flop synchronizers on I_pad0/I_pad1 (reset 8'h00).
module joypad_port #(
  parameter logic [15:0] BASE_ADDR = 16'h4016,
  parameter logic [2:0]  OPEN_BITS = 3'b010
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_ready,
  input  logic        I_phy2,
  input  logic [15:0] I_addr,
  input  logic        I_rdwr,
  input  logic [7:0]  I_wr_data,
  output logic [7:0]  O_rd_data,
  output logic        O_rd_en,
  input  logic [7:0]  I_pad0,
  input  logic [7:0]  I_pad1,
  output logic [2:0]  O_out
);

  logic [7:0] pad0_s;
  logic [7:0] pad1_s;
  logic       phy2_q;
  logic       fall;
  logic       hit0;
  logic       hit1;
  logic [7:0] sh0;
  logic [7:0] sh1;
  logic       unused_wr_bits;

`ifdef JOYPAD_SYNC_EN
  logic [7:0] pad0_m;
  logic [7:0] pad1_m;

  // Two-flop synchronizers for asynchronous controller inputs
  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      pad0_m <= 8'h00;
      pad1_m <= 8'h00;
      pad0_s <= 8'h00;
      pad1_s <= 8'h00;
    end else begin
      pad0_m <= I_pad0;
      pad1_m <= I_pad1;
      pad0_s <= pad0_m;
      pad1_s <= pad1_m;
    end
  end
`else
  assign pad0_s = I_pad0;
  assign pad1_s = I_pad1;
`endif

  // Only OUT2..OUT0 are stored; the upper write-data bits have no function here
  assign unused_wr_bits = ^I_wr_data[7:3];

  assign hit0 = (I_addr == BASE_ADDR);
  assign hit1 = (I_addr == BASE_ADDR + 16'd1);
  assign fall = phy2_q & ~I_phy2 & I_ready;

  // Track phy2 so the commit edge can be detected; a stalled bus holds the history
  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      phy2_q <= 1'b0;
    end else if (I_ready) begin
      phy2_q <= I_phy2;
    end
  end

  // OUT latch updated by a committed write to port 0; port-1 writes are ignored
  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      O_out <= 3'b000;
    end else if (fall && !I_rdwr && hit0) begin
      O_out <= I_wr_data[2:0];
    end
  end

  // Shift registers: reload every clock while strobed, shift in 1s on committed reads otherwise
  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      sh0 <= 8'hFF;
      sh1 <= 8'hFF;
    end else if (O_out[0]) begin
      sh0 <= pad0_s;
      sh1 <= pad1_s;
    end else if (fall && I_rdwr) begin
      if (hit0) begin
        sh0 <= {1'b1, sh0[7:1]};
      end
      if (hit1) begin
        sh1 <= {1'b1, sh1[7:1]};
      end
    end
  end

  assign O_rd_en = I_phy2 & I_rdwr & (hit0 | hit1);

  // Read data mux: current LSB of the addressed port, open-bus pattern on top
  always_comb begin
    O_rd_data = 8'h00;
    if (O_rd_en) begin
      O_rd_data = {OPEN_BITS, 4'b0000, (hit0 ? sh0[0] : sh1[0])};
    end
  end

endmodule

// File: tb/tb_joypad_port.sv
// tb_joypad_port: randomized and directed checks of joypad_port against a button-count model.
// The model remembers the buttons captured when the strobe drops and how many reads each port has seen.
module tb_joypad_port;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ready = 1'b1;
  logic        phy2 = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic        rdwr = 1'b1;
  logic [7:0]  wr_data = 8'h00;
  logic [7:0]  rd_data;
  logic        rd_en;
  logic [7:0]  pad0 = 8'h00;
  logic [7:0]  pad1 = 8'h00;
  logic [2:0]  out;

  int          n_vec = 0;
  int          n_bad = 0;

  logic [2:0]  m_out;
  logic [7:0]  snap [2];
  int          cnt [2];
  logic [7:0]  last_rd;

  joypad_port dut (
    .I_clock   (clock),
    .I_reset   (reset),
    .I_ready   (ready),
    .I_phy2    (phy2),
    .I_addr    (addr),
    .I_rdwr    (rdwr),
    .I_wr_data (wr_data),
    .O_rd_data (rd_data),
    .O_rd_en   (rd_en),
    .I_pad0    (pad0),
    .I_pad1    (pad1),
    .O_out     (out)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    n_vec++;
    if (observed !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
    end
  endtask

  // Button value the controller should present next: live A while strobed,
  // then the captured buttons A..Right, then 1 forever
  function automatic logic model_bit(input int port);
    logic [7:0] live;
    live = (port == 1) ? pad1 : pad0;
    if (m_out[0]) return live[0];
    if (cnt[port] >= 8) return 1'b1;
    return snap[port][cnt[port]];
  endfunction

  task automatic model_reset();
    m_out = 3'b000;
    cnt[0] = 8;
    cnt[1] = 8;
    snap[0] = 8'hFF;
    snap[1] = 8'hFF;
  endtask

  task automatic doReset();
    @(posedge clock); #1;
    reset = 1'b1; phy2 = 1'b0; addr = 16'h0000; ready = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    checkOutput("reset_out", {5'b0, out}, 8'h00);
    checkOutput("reset_rd_en", {7'b0, rd_en}, 8'h00);
  endtask

  // One full bus cycle: phy2 high for a clock, then the fall with the chosen ready level
  task automatic applyStimulus(input logic [15:0] a, input logic rw, input logic [7:0] d, input logic rdy);
    logic       exp_en;
    logic [7:0] exp_data;
    int         port;
    @(posedge clock); #1;
    addr = a; rdwr = rw; wr_data = d; phy2 = 1'b1; ready = 1'b1;
    @(posedge clock); #1;
    exp_en = rw && (a == 16'h4016 || a == 16'h4017);
    port = (a == 16'h4017) ? 1 : 0;
    exp_data = exp_en ? {3'b010, 4'b0000, model_bit(port)} : 8'h00;
    checkOutput("rd_en", {7'b0, rd_en}, {7'b0, exp_en});
    checkOutput("rd_data", rd_data, exp_data);
    last_rd = rd_data;
    phy2 = 1'b0; ready = rdy;
    @(posedge clock); #1;
    if (rdy) begin
      if (!rw && a == 16'h4016) begin
        if (m_out[0]) begin
          snap[0] = pad0; snap[1] = pad1;
          cnt[0] = 0; cnt[1] = 0;
        end
        m_out = d[2:0];
      end else if (exp_en && !m_out[0] && cnt[port] < 8) begin
        cnt[port]++;
      end
    end
    checkOutput("out", {5'b0, out}, {5'b0, m_out});
    addr = 16'h0000; rdwr = 1'b1; phy2 = 1'b0; ready = 1'b1;
  endtask

  initial begin
    model_reset();
    last_rd = 8'h00;
    repeat (2) @(posedge clock);
    doReset();

    // Strobed reads return live A and never shift
    pad0 = 8'hA5;
    applyStimulus(16'h4016, 1'b0, 8'h01, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'h4016, 1'b1, 8'h00, 1'b1);
      checkOutput("strobe_read", last_rd, 8'h41);
    end

    // Release strobe, eight serial bits then 1-fill
    applyStimulus(16'h4016, 1'b0, 8'h00, 1'b1);
    pad0 = 8'h00;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(16'h4016, 1'b1, 8'h00, 1'b1);
    end
    checkOutput("fill_read", last_rd, 8'h41);

    // Port 1 independent of interleaved port 0 reads
    pad1 = 8'h02;
    applyStimulus(16'h4016, 1'b0, 8'h01, 1'b1);
    applyStimulus(16'h4016, 1'b0, 8'h00, 1'b1);
    applyStimulus(16'h4017, 1'b1, 8'h00, 1'b1);
    checkOutput("p1_first", last_rd, 8'h40);
    applyStimulus(16'h4016, 1'b1, 8'h00, 1'b1);
    applyStimulus(16'h4016, 1'b1, 8'h00, 1'b1);
    applyStimulus(16'h4017, 1'b1, 8'h00, 1'b1);
    checkOutput("p1_second", last_rd, 8'h41);

    // Stalled read must not shift; the retried read shifts once
    pad0 = 8'h02;
    applyStimulus(16'h4016, 1'b0, 8'h01, 1'b1);
    applyStimulus(16'h4016, 1'b0, 8'h00, 1'b1);
    applyStimulus(16'h4016, 1'b1, 8'h00, 1'b0);
    applyStimulus(16'h4016, 1'b1, 8'h00, 1'b1);
    checkOutput("retry_read", last_rd, 8'h40);
    applyStimulus(16'h4016, 1'b1, 8'h00, 1'b1);
    checkOutput("after_retry", last_rd, 8'h41);

    // Reset mid-sequence
    pad0 = 8'h00; pad1 = 8'h00;
    applyStimulus(16'h4016, 1'b0, 8'h05, 1'b1);
    applyStimulus(16'h4016, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(16'h4016, 1'b1, 8'h00, 1'b1);
    doReset();
    applyStimulus(16'h4016, 1'b1, 8'h00, 1'b1);
    checkOutput("post_reset_p0", last_rd, 8'h41);
    applyStimulus(16'h4017, 1'b1, 8'h00, 1'b1);
    checkOutput("post_reset_p1", last_rd, 8'h41);

    // Port-1 writes ignored, port-0 write latches OUT, unmapped read stays off the bus
    applyStimulus(16'h4017, 1'b0, 8'h07, 1'b1);
    checkOutput("w4017_out", {5'b0, out}, 8'h00);
    applyStimulus(16'h4016, 1'b0, 8'h06, 1'b1);
    checkOutput("w4016_out", {5'b0, out}, 8'h06);
    applyStimulus(16'h4015, 1'b1, 8'h00, 1'b1);

    // Randomized bus traffic against the model
    for (int i = 0; i < 400; i++) begin
      int          r;
      logic [15:0] a;
      logic        rdy;
      r = int'($urandom_range(0, 19));
      rdy = ($urandom_range(0, 5) != 0);
      case ($urandom_range(0, 3))
        0: a = 16'h4015;
        1: a = 16'h4018;
        2: a = 16'($urandom);
        default: a = 16'h4016;
      endcase
      if (r < 4) begin
        applyStimulus(16'h4016, 1'b0, 8'($urandom), rdy);
      end else if (r < 5) begin
        applyStimulus(16'h4017, 1'b0, 8'($urandom), rdy);
      end else if (r < 10) begin
        applyStimulus(16'h4016, 1'b1, 8'h00, rdy);
      end else if (r < 15) begin
        applyStimulus(16'h4017, 1'b1, 8'h00, rdy);
      end else if (r < 17) begin
        applyStimulus(a, 1'($urandom_range(0, 1)), 8'($urandom), rdy);
      end else if (r < 19) begin
        pad0 = 8'($urandom);
        pad1 = 8'($urandom);
      end else begin
        doReset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
